spi_regfile_peripheral: RTL and testbench
=========================================

# spi_regfile_peripheral

Parametrised SPI mode-0 slave exposing a bank of `NUM_REGS` configuration registers of `DATA_W` bits each to the chip core. It is the successor to the fixed five-register write-only SPI peripheral. Additions over that block: configurable width and depth, strict frame-length checking, write/error strobes, and optional register readback on MISO. It sits between the chip's SPI pins and the PWM/output-enable logic, in the same clock domain as that logic.

## Interface
Parameters:
- `NUM_REGS`, 5: number of registers; must be ≤ 2^`ADDR_W`.
- `ADDR_W`, 7: address field width in the frame.
- `DATA_W`, 8: register and data field width.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `sclk_raw`  in  1: SPI clock, asynchronous to `clk`.
- `mosi_raw`  in  1: SPI data in, asynchronous to `clk`.
- `cs_n_raw`  in  1: SPI chip select, active-low, asynchronous to `clk`.
- `miso`  out  1: SPI data out.
- `miso_oe`  out  1: pad output enable for `miso`.
- `regs_flat`  out  `NUM_REGS*DATA_W`: all registers concatenated; register *i* is bits [i*`DATA_W` +: `DATA_W`].
- `wr_pulse`  out  1: one-cycle strobe when a write commits.
- `wr_addr`  out  `ADDR_W`: address of the last committed write.
- `frame_err`  out  1: one-cycle strobe when a frame is rejected for wrong length.

## Operation
- Frame layout, MSB first: bit 0 is R/W (1 = write), then `ADDR_W` address bits, then `DATA_W` data bits. Total `FRAME_BITS` = 1 + `ADDR_W` + `DATA_W` (16 at defaults).
- All three raw inputs pass through 2-flop synchronisers. A third flop per SCLK and CS_N provides edge detection.
- At reset, the synchronised `cs_n` resets to 1 and `sclk` resets to 0, so reset release never produces a phantom frame.
- Synchronised CS_N falling edge: clear `bit_cnt` and the RX shift register.
- While CS_N is low, each synchronised SCLK rising edge shifts `mosi` into the RX register LSB and increments `bit_cnt`.
- `bit_cnt` saturates at `FRAME_BITS`+1, which marks an overlength frame.
- Synchronised CS_N rising edge (end of frame):
  - If `bit_cnt` ≠ `FRAME_BITS`: discard the frame and pulse `frame_err`. No register changes.
  - Else if it is a write and address < `NUM_REGS`: update the register, pulse `wr_pulse`, load `wr_addr`.
  - Else (read frame, or address ≥ `NUM_REGS`): no action and no error.
- Assertion of `rst_n` mid-frame clears all state. The partial frame is lost. The next frame starts cleanly at the next CS_N falling edge.
- SCLK edges while CS_N is high are ignored.

## Timing
- Reset values: `regs_flat` = 0, `wr_addr` = 0, `wr_pulse` = 0, `frame_err` = 0, `miso` = 0, `miso_oe` = 0.
- Commit latency: let E0 be the first `clk` edge at which `cs_n_raw` is sampled high.
  - The rise is detected after E1.
  - `regs_flat`, `wr_pulse` and `frame_err` change at E2.
  - Strobes last exactly one cycle.
- SCLK frequency must be ≤ `clk`/8. Minimum CS_N high time between frames is 4 `clk` cycles.
- Back-to-back frames that meet this constraint each commit independently.

## Configuration
- `SPI_READBACK_EN` defined:
  - After the 1+`ADDR_W` command bits of a read frame, the TX shift register loads the addressed register. An out-of-range address loads 0.
  - `miso` drives the TX MSB and shifts on each synchronised SCLK falling edge.
  - During the command phase, `miso` = 0.
  - `miso_oe` = synchronised CS_N low.
- `SPI_READBACK_EN` undefined:
  - `miso` and `miso_oe` are tied to 0.
  - The TX logic is absent.
  - Read frames are still length-checked.

## Structure
- Package `spi_pkg` holds:
  - localparams for R/W bit index and `FRAME_BITS` derivation.
  - write/read opcode constants.
- Sub-module `spi_input_sync`: one generic 2-flop synchroniser plus prev flop, with parameterised reset value, providing rise and fall outputs. It is instantiated once each for SCLK, MOSI and CS_N (MOSI does not use the edge outputs).

## Test plan
- Write 0x81 then 0x5A (write, address 1, data 0x5A) at defaults -> `regs_flat`[15:8] = 0x5A. `wr_pulse` high for one cycle with `wr_addr` = 1. Other registers stay 0.
- Write to address 5 (0x85, 0xFF) -> no register change, no `wr_pulse`, no `frame_err`.
- Frames of 15 and 17 SCLK edges, each a write to address 0 -> `frame_err` pulses once per frame. `regs_flat` is unchanged.
- Read 0x02 then 0x00, following a write of 0xC3 to address 2, with `SPI_READBACK_EN` defined -> `miso` presents 0xC3 MSB-first on SCLK edges 9–16. `miso_oe` is high only while CS_N is low. Without the macro, `miso` stays 0 throughout.
- Assert `rst_n` after 8 SCLK edges of a write, then send a full write of 0x84, 0x33 -> only `regs_flat`[39:32] = 0x33. No spurious strobe at reset release.
- Parameter sweep with `NUM_REGS`=16, `ADDR_W`=4, `DATA_W`=16 (21-bit frames) -> writes and reads to addresses 0 and 15 round-trip correctly.

Source files
------------

// File: rtl/spi_regfile_peripheral_pkg.sv
// Shared constants for the SPI register-file peripheral: frame geometry and
// R/W opcode values.
package spi_pkg;

  // Position of the R/W flag within the frame, counted from the first bit sent.
  localparam int RW_BIT_POS = 0;

  // Opcode carried in the R/W flag.
  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  // Total frame length: R/W flag, address field, data field.
  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// Pin-side and core-side signal bundle of the SPI register-file peripheral.
interface spi_regfile_peripheral_if #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
);
  logic                         sclk_raw;
  logic                         mosi_raw;
  logic                         cs_n_raw;
  logic                         miso;
  logic                         miso_oe;
  logic [NUM_REGS*DATA_W-1:0]   regs_flat;
  logic                         wr_pulse;
  logic [ADDR_W-1:0]            wr_addr;
  logic                         frame_err;

  modport slave (
    input  sclk_raw, mosi_raw, cs_n_raw,
    output miso, miso_oe, regs_flat, wr_pulse, wr_addr, frame_err
  );

  modport master (
    output sclk_raw, mosi_raw, cs_n_raw,
    input  miso, miso_oe, regs_flat, wr_pulse, wr_addr, frame_err
  );
endinterface

// File: rtl/spi_regfile_peripheral_sync.sv
// Two-flop synchroniser with a trailing history flop for edge detection.
// RST_VAL sets the idle level the line is assumed to hold while in reset.
module spi_input_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resynchronise the raw line and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= d_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign q    = r_sync;
  assign rise = r_sync & ~r_prev;
  assign fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 slave exposing NUM_REGS registers of DATA_W bits to the core.
// Frame: R/W flag, ADDR_W address bits, DATA_W data bits, MSB first.
// Optional feature macro: SPI_READBACK_EN (register readback on MISO).
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  spi_regfile_peripheral_if.slave bus
);
  localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
  localparam int RW_IDX     = FRAME_BITS - 1 - RW_BIT_POS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_cs_n, w_cs_rise, w_cs_fall;

  spi_input_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_raw(bus.sclk_raw),
    .q(w_sclk), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );
  spi_input_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_raw(bus.mosi_raw),
    .q(w_mosi), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
  );
  spi_input_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_raw(bus.cs_n_raw),
    .q(w_cs_n), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  logic [FRAME_BITS-1:0]      r_rx;
  logic [CNT_W-1:0]           r_bit_cnt;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic                       r_wr_pulse;
  logic [ADDR_W-1:0]          r_wr_addr;
  logic                       r_frame_err;

  logic [FRAME_BITS-1:0] w_rx_next;
  logic                  w_shift;
  logic                  w_rw;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_data;
  logic                  w_len_ok;
  logic                  w_in_range;
  logic                  w_sclk_level_unused;

  assign w_sclk_level_unused = w_sclk;
  assign w_rx_next  = {r_rx[FRAME_BITS-2:0], w_mosi};
  assign w_shift    = ~w_cs_n & w_sclk_rise;
  assign w_rw       = r_rx[RW_IDX];
  assign w_addr     = r_rx[DATA_W +: ADDR_W];
  assign w_data     = r_rx[DATA_W-1:0];
  assign w_len_ok   = (r_bit_cnt == CNT_FULL);
  assign w_in_range = ({1'b0, w_addr} < NUM_REGS_L);

  // Receive shifter and saturating bit counter, restarted at every CS_N fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else if (w_cs_fall) begin
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_rx <= w_rx_next;
      if (r_bit_cnt != CNT_SAT) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // End-of-frame commit: length check, then in-range writes update the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs      <= '0;
      r_wr_pulse  <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_pulse  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_cs_rise) begin
        if (!w_len_ok) begin
          r_frame_err <= 1'b1;
        end else if ((w_rw == OP_WRITE) && w_in_range) begin
          r_wr_pulse <= 1'b1;
          r_wr_addr  <= w_addr;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr == ADDR_W'(i)) begin
              r_regs[i*DATA_W +: DATA_W] <= w_data;
            end
          end
        end
      end
    end
  end

  assign bus.regs_flat = r_regs;
  assign bus.wr_pulse  = r_wr_pulse;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_cmd_rw;
  logic [ADDR_W-1:0] w_cmd_addr;

  // Command bits as they stand once the current SCLK rise is absorbed.
  assign w_cmd_rw   = w_rx_next[ADDR_W];
  assign w_cmd_addr = w_rx_next[ADDR_W-1:0];

  // Readback mux; out-of-range addresses read as zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_cmd_addr == ADDR_W'(i)) begin
        w_rd_val = r_regs[i*DATA_W +: DATA_W];
      end
    end
  end

  // TX shifter: load on the last command bit, shift on falls during the data
  // phase only, so the first data bit is still on MISO at the next SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= '0;
    end else if (w_cs_fall) begin
      r_tx <= '0;
    end else if (w_shift && (r_bit_cnt == CNT_W'(ADDR_W))) begin
      r_tx <= (w_cmd_rw == OP_READ) ? w_rd_val : '0;
    end else if (~w_cs_n && w_sclk_fall && (r_bit_cnt > CNT_W'(ADDR_W + 1))) begin
      r_tx <= r_tx << 1;
    end
  end

  assign bus.miso    = r_tx[DATA_W-1];
  assign bus.miso_oe = ~w_cs_n;
`else
  logic w_sclk_fall_unused;
  assign w_sclk_fall_unused = w_sclk_fall;
  assign bus.miso    = 1'b0;
  assign bus.miso_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench: two DUTs (default 5x8 bank and a 16x16 bank) share SCLK
// and MOSI but have separate chip selects. Expected strobes are queued as
// frames are issued; a monitor per DUT pops and checks on every strobe.
module tb_spi_regfile_peripheral;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sclk, mosi, cs_a, cs_b;

  spi_regfile_peripheral_if #(.NUM_REGS(5),  .ADDR_W(7), .DATA_W(8))  ifa ();
  spi_regfile_peripheral_if #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) ifb ();

  assign ifa.sclk_raw = sclk;
  assign ifa.mosi_raw = mosi;
  assign ifa.cs_n_raw = cs_a;
  assign ifb.sclk_raw = sclk;
  assign ifb.mosi_raw = mosi;
  assign ifb.cs_n_raw = cs_b;

  spi_regfile_peripheral #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  spi_regfile_peripheral #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct {
    logic         err;
    logic [6:0]   addr;
    logic [255:0] regs;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [39:0]  exp_a;
  logic [255:0] exp_b;
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic err, input logic [6:0] addr);
    exp_t e;
    e.err = err; e.addr = addr; e.regs = {216'd0, exp_a};
    qa.push_back(e);
  endtask

  task automatic push_b(input logic err, input logic [6:0] addr);
    exp_t e;
    e.err = err; e.addr = addr; e.regs = exp_b;
    qb.push_back(e);
  endtask

  // Monitor for the default-size DUT.
  always @(negedge clk) begin
    if (prev_a) check("a_strobe_width", {254'd0, ifa.wr_pulse, ifa.frame_err}, 256'd0);
    if (ifa.wr_pulse || ifa.frame_err) begin
      if (qa.size() == 0) begin
        check("a_unexpected_strobe", {254'd0, ifa.wr_pulse, ifa.frame_err}, 256'd0);
      end else begin
        ea = qa.pop_front();
        check("a_kind", {254'd0, ifa.wr_pulse, ifa.frame_err}, ea.err ? 256'd1 : 256'd2);
        if (!ea.err) check("a_wr_addr", {249'd0, ifa.wr_addr}, {249'd0, ea.addr});
        check("a_regs", {216'd0, ifa.regs_flat}, ea.regs);
      end
    end
    prev_a <= ifa.wr_pulse | ifa.frame_err;
  end

  // Monitor for the wide DUT.
  always @(negedge clk) begin
    if (prev_b) check("b_strobe_width", {254'd0, ifb.wr_pulse, ifb.frame_err}, 256'd0);
    if (ifb.wr_pulse || ifb.frame_err) begin
      if (qb.size() == 0) begin
        check("b_unexpected_strobe", {254'd0, ifb.wr_pulse, ifb.frame_err}, 256'd0);
      end else begin
        eb = qb.pop_front();
        check("b_kind", {254'd0, ifb.wr_pulse, ifb.frame_err}, eb.err ? 256'd1 : 256'd2);
        if (!eb.err) check("b_wr_addr", {252'd0, ifb.wr_addr}, {249'd0, eb.addr});
        check("b_regs", ifb.regs_flat, eb.regs);
      end
    end
    prev_b <= ifb.wr_pulse | ifb.frame_err;
  end

  // One SPI transaction of nbits (MSB first), SCLK period 10 clk cycles.
  // MISO/OE are sampled at each SCLK rise, as a mode-0 master would.
  // abort: pulse rst_n while CS_N is still low instead of ending cleanly.
  task automatic spi_xfer(input bit to_b, input logic [31:0] word, input int nbits,
                          input bit abort, output logic [31:0] mb, output int oe_cnt);
    mb = 32'd0;
    oe_cnt = 0;
    @(negedge clk);
    if (to_b) cs_b = 1'b0; else cs_a = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = word[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      mb = {mb[30:0], (to_b ? ifb.miso : ifa.miso)};
      if (to_b ? ifb.miso_oe : ifa.miso_oe) oe_cnt++;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (abort) begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
    end
    cs_a = 1'b1;
    cs_b = 1'b1;
    mosi = 1'b0;
    if (abort) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  logic [31:0] mb;
  int oe_cnt;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
    exp_a = 40'd0; exp_b = 256'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state.
    check("rst_regs_a",   {216'd0, ifa.regs_flat}, 256'd0);
    check("rst_wr_addr",  {249'd0, ifa.wr_addr},   256'd0);
    check("rst_wr_pulse", {255'd0, ifa.wr_pulse},  256'd0);
    check("rst_frame_err",{255'd0, ifa.frame_err}, 256'd0);
    check("rst_miso",     {255'd0, ifa.miso},      256'd0);
    check("rst_miso_oe",  {255'd0, ifa.miso_oe},   256'd0);
    check("rst_regs_b",   ifb.regs_flat,           256'd0);

    // Write 0x5A to address 1.
    exp_a[15:8] = 8'h5A;
    push_a(1'b0, 7'd1);
    spi_xfer(1'b0, 32'h0000_815A, 16, 1'b0, mb, oe_cnt);
    check("t1_regs", {216'd0, ifa.regs_flat}, {216'd0, exp_a});
    check("t1_wr_addr", {249'd0, ifa.wr_addr}, 256'd1);

    // Write to out-of-range address 5: silent.
    spi_xfer(1'b0, 32'h0000_85FF, 16, 1'b0, mb, oe_cnt);
    check("t2_regs", {216'd0, ifa.regs_flat}, {216'd0, exp_a});
    check("t2_wr_addr", {249'd0, ifa.wr_addr}, 256'd1);

    // Short (15) and long (17) writes to address 0: frame errors only.
    push_a(1'b1, 7'd0);
    spi_xfer(1'b0, 32'h0000_4055, 15, 1'b0, mb, oe_cnt);
    push_a(1'b1, 7'd0);
    spi_xfer(1'b0, 32'h0001_0155, 17, 1'b0, mb, oe_cnt);
    check("t3_regs", {216'd0, ifa.regs_flat}, {216'd0, exp_a});

    // Write 0xC3 to address 2, then read it back.
    exp_a[23:16] = 8'hC3;
    push_a(1'b0, 7'd2);
    spi_xfer(1'b0, 32'h0000_82C3, 16, 1'b0, mb, oe_cnt);
    spi_xfer(1'b0, 32'h0000_0200, 16, 1'b0, mb, oe_cnt);
`ifdef SPI_READBACK_EN
    check("t4_miso_bits", {224'd0, mb}, 256'h00C3);
    check("t4_oe_in_frame", 256'(oe_cnt), 256'd16);
`else
    check("t4_miso_bits", {224'd0, mb}, 256'd0);
    check("t4_oe_in_frame", 256'(oe_cnt), 256'd0);
`endif
    check("t4_oe_idle", {255'd0, ifa.miso_oe}, 256'd0);
    check("t4_regs", {216'd0, ifa.regs_flat}, {216'd0, exp_a});

    // Reset in the middle of a write, then a clean write of 0x33 to address 4.
    spi_xfer(1'b0, 32'h0000_0081, 8, 1'b1, mb, oe_cnt);
    exp_a = 40'd0;
    exp_b = 256'd0;
    check("t5_regs_after_rst", {216'd0, ifa.regs_flat}, 256'd0);
    check("t5_wr_addr_after_rst", {249'd0, ifa.wr_addr}, 256'd0);
    exp_a[39:32] = 8'h33;
    push_a(1'b0, 7'd4);
    spi_xfer(1'b0, 32'h0000_8433, 16, 1'b0, mb, oe_cnt);
    check("t5_regs", {216'd0, ifa.regs_flat}, {216'd0, exp_a});

    // Wide DUT: 21-bit frames, addresses 0 and 15.
    exp_b[15:0] = 16'h1234;
    push_b(1'b0, 7'd0);
    spi_xfer(1'b1, 32'h0010_1234, 21, 1'b0, mb, oe_cnt);
    exp_b[255:240] = 16'hBEEF;
    push_b(1'b0, 7'd15);
    spi_xfer(1'b1, 32'h001F_BEEF, 21, 1'b0, mb, oe_cnt);
    check("t6_regs_b", ifb.regs_flat, exp_b);
    spi_xfer(1'b1, 32'h0000_0000, 21, 1'b0, mb, oe_cnt);
`ifdef SPI_READBACK_EN
    check("t6_read0", {224'd0, mb}, 256'h1234);
`else
    check("t6_read0", {224'd0, mb}, 256'd0);
`endif
    spi_xfer(1'b1, 32'h000F_0000, 21, 1'b0, mb, oe_cnt);
`ifdef SPI_READBACK_EN
    check("t6_read15", {224'd0, mb}, 256'hBEEF);
`else
    check("t6_read15", {224'd0, mb}, 256'd0);
`endif
    check("t6_regs_a_untouched", {216'd0, ifa.regs_flat}, {216'd0, exp_a});

    repeat (20) @(negedge clk);
    check("qa_drained", 256'(qa.size()), 256'd0);
    check("qb_drained", 256'(qb.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
